truth_table_eval: RTL and testbench
===================================

# truth_table_eval

Programmable N-input, M-output truth-table evaluator. It is the parametrised successor of the fixed 3-input, single-output logic modules in the DNACompiler sample set. The truth table is loaded at run time through a serial configuration handshake, and input vectors are evaluated through a registered, back-pressured valid/ready pipeline. It sits between a stimulus source and a circuit-scoring or compare stage, so that any Wolfram-style function can be exercised without regenerating RTL.

## Interface
- N_IN, 3, number of inputs; 1..8
- N_OUT, 1, number of outputs; 1..8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cfg_start  input  1  one-cycle pulse; begins a table load, discarding the old table
- cfg_valid  input  1  cfg_bit is valid
- cfg_bit  input  1  serial table bit
- cfg_ready  output  1  block accepts a cfg bit
- cfg_done  output  1  table loaded and accepted; stays high while in RUN
- cfg_err  output  1  parity failure; only exists when the macro is defined, otherwise tied 0
- in_valid  input  1  input vector valid
- in_data  input  N_IN  input vector; bit N_IN-1 is the leftmost input (in1)
- in_ready  output  1  input accepted this cycle when in_valid is also high
- out_valid  output  1  out_data valid
- out_data  output  N_OUT  evaluated function
- out_ready  input  1  consumer accepts out_data

## Operation
- The FSM has four states: IDLE, LOAD, RUN and ERR. After reset the state is IDLE and the table is all zeros.
- Any state goes to LOAD on cfg_start. In LOAD the bit counter clears, cfg_done drops, and out_valid is cleared.
- Load order: TBITS = N_OUT·2^N_IN.
  - bit k is stored in table[k]; the counter width is clog2(TBITS+1).
  - Entry index e for output j is at k = j·2^N_IN + e, where e = in_data.
  - Bits are sent LSB first.
- cfg_ready = (state==LOAD). A bit transfers when cfg_valid && cfg_ready.
- LOAD goes to RUN after the final transfer. With parity enabled, it goes to RUN or ERR after the parity bit instead.
- ERR holds until cfg_start or reset. In ERR, cfg_err=1, in_ready=0 and the table is unusable.
- In RUN, in_ready = !out_valid || out_ready. On an input transfer, out_data[j] <= table[j·2^N_IN + in_data] and out_valid <= 1.
- out_valid falls on out_ready when no new input is transferred in the same cycle.
- in_ready=0 in IDLE, LOAD and ERR. in_valid in those states is ignored and nothing is queued.
- If cfg_start arrives in the same cycle as an input transfer, cfg_start wins: the input is dropped and out_valid is cleared.
- If cfg_start arrives mid-load, the load restarts from k=0.
- Reset mid-operation returns to IDLE and zeroes the table.

## Timing
- Reset values: cfg_ready=0, cfg_done=0, cfg_err=0, in_ready=0, out_valid=0, out_data=0.
- Load duration is TBITS cycles of back-to-back transfers (TBITS+1 with parity). cfg_done rises in the cycle after the last transfer.
- Evaluation latency is 1 cycle from the input transfer to out_valid.
- Throughput is 1 vector per cycle while out_ready=1.
- out_data is stable while out_valid && !out_ready.
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.

## Configuration
- TRUTH_TABLE_EVAL_PARITY_EN
  - Defined: LOAD expects one extra bit after the table, such that the XOR of all TBITS+1 bits is 0 (even parity). A match goes to RUN; a mismatch goes to ERR with cfg_err=1.
  - Undefined: there is no parity bit, the ERR state is absent, and cfg_err is constant 0.

## Structure
- Package truth_table_eval_pkg holds:
  - the state enum (IDLE, LOAD, RUN, ERR)
  - the TBITS helper function
  - Wolfram-code constants for test tables
- One sub-module, tt_out_stage: the 1-entry valid/ready output register carrying N_OUT bits.
- The table is a flat TBITS-bit register. No RAM is used.

## Test plan
- N_IN=3, N_OUT=1, load 8'h40 (entry 6 = 1), then sweep in_data 0..7 with out_ready=1 → out_data is 1 only for 3'b110; out_valid follows each input after 1 cycle.
- N_OUT=2, load table 16'hE896, hold out_ready=0 for 3 cycles after the first vector → in_ready=0 and out_data stable; the vector after release is accepted in the same cycle.
- cfg_start after 4 of 8 bits, then a full reload of 8'hFF → the counter restarts and every input evaluates to 1.
- Assert rst while out_valid=1 in RUN → all outputs 0 in the same cycle, state IDLE, and in_ready=0 after release.
- in_valid=1 held continuously during LOAD → no transfer and out_valid stays 0 until RUN.
- With TRUTH_TABLE_EVAL_PARITY_EN: table 8'h40 with parity bit 0 → cfg_err=1, in_ready=0. With parity bit 1 → cfg_done=1.

Source files
------------

// File: rtl/truth_table_eval_pkg.sv
// Shared types and helpers for the run-time programmable truth-table evaluator.
// Holds the FSM state encoding, the table-size helper and reference Wolfram codes.
// Imported by truth_table_eval and its testbench.
package truth_table_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } tt_state_t;

    // Number of table bits: one 2^n_in-entry column per output.
    function automatic int tt_bits(input int n_in, input int n_out);
        return n_out * (1 << n_in);
    endfunction

    // Wolfram-style 3-input codes used as reference tables.
    localparam logic [7:0] WOLFRAM_ONLY_110 = 8'h40;
    localparam logic [7:0] WOLFRAM_ALL_ONES = 8'hFF;
    localparam logic [7:0] WOLFRAM_MAJ      = 8'hE8;
    localparam logic [7:0] WOLFRAM_XOR3     = 8'h96;

endpackage

// File: rtl/tt_out_stage.sv
// One-entry valid/ready output register carrying the evaluated N_OUT bits.
// Latency: 1 cycle from accept to o_vld; full throughput while i_rdy is high.
// Backpressure: o_rdy = !o_vld || i_rdy; data held stable while o_vld && !i_rdy.
module tt_out_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_vld,
    output logic         o_rdy,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    input  logic         i_rdy
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    assign o_rdy = !r_vld || i_rdy;
    assign o_vld = r_vld;
    assign o_dat = r_dat;

    // Capture on accept, drain on consumer ready; flush drops any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_vld && o_rdy) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/truth_table_eval.sv
// Programmable N_IN-input / N_OUT-output truth table, loaded serially LSB first.
// Latency: 1 cycle input->out_valid; table load takes TBITS transfers (+1 parity bit).
// Backpressure: in_ready = RUN && (!out_valid || out_ready); optional even parity via TRUTH_TABLE_EVAL_PARITY_EN.
module truth_table_eval
    import truth_table_eval_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_data,
    input  logic             out_ready
);

    localparam int ROWS  = 1 << N_IN;
    localparam int TBITS = tt_bits(N_IN, N_OUT);
    localparam int CW    = $clog2(TBITS + 1);
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
    // The parity bit travels at k == TBITS, after the last table bit.
    localparam logic [CW-1:0] LAST_K = CW'(TBITS);
`else
    localparam logic [CW-1:0] LAST_K = CW'(TBITS - 1);
`endif

    tt_state_t          r_state;
    logic [TBITS-1:0]   r_table;
    logic [CW-1:0]      r_cnt;
    logic               r_cfg_ready;
    logic               r_cfg_done;
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
    logic               r_par;
    logic               r_cfg_err;
`endif

    logic               w_cfg_xfer;
    logic               w_stage_rdy;
    logic               w_in_ready;
    logic               w_in_xfer;
    logic [N_OUT-1:0]   w_eval;

    assign w_cfg_xfer = cfg_valid && r_cfg_ready;
    assign w_in_ready = (r_state == ST_RUN) && w_stage_rdy;
    // cfg_start takes priority over a simultaneous input: the vector is dropped.
    assign w_in_xfer  = in_valid && w_in_ready && !cfg_start;

    assign cfg_ready  = r_cfg_ready;
    assign cfg_done   = r_cfg_done;
    assign in_ready   = w_in_ready;
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
    assign cfg_err    = r_cfg_err;
`else
    assign cfg_err    = 1'b0;
`endif

    // Control FSM: table load, bit counter, parity and registered cfg flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_table     <= '0;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b0;
            r_cfg_done  <= 1'b0;
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
            r_par       <= 1'b0;
            r_cfg_err   <= 1'b0;
`endif
        end else if (cfg_start) begin
            r_state     <= ST_LOAD;
            r_table     <= '0;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_done  <= 1'b0;
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
            r_par       <= 1'b0;
            r_cfg_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_cfg_xfer) begin
                        for (int k = 0; k < TBITS; k++) begin
                            if (r_cnt == CW'(k)) r_table[k] <= cfg_bit;
                        end
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
                        r_par <= r_par ^ cfg_bit;
`endif
                        if (r_cnt == LAST_K) begin
                            r_cfg_ready <= 1'b0;
`ifdef TRUTH_TABLE_EVAL_PARITY_EN
                            if (r_par ^ cfg_bit) begin
                                r_state   <= ST_ERR;
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_state    <= ST_RUN;
                                r_cfg_done <= 1'b1;
                            end
`else
                            r_state    <= ST_RUN;
                            r_cfg_done <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE, RUN and ERR only leave on cfg_start or reset.
                end
            endcase
        end
    end

    // Table lookup: output j reads column j at row in_data.
    always_comb begin
        logic [ROWS-1:0] w_row;
        w_eval = '0;
        w_row  = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_row     = r_table[j*ROWS +: ROWS];
            w_eval[j] = w_row[in_data];
        end
    end

    tt_out_stage #(
        .W (N_OUT)
    ) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .i_flush (cfg_start),
        .i_vld   (w_in_xfer),
        .o_rdy   (w_stage_rdy),
        .i_dat   (w_eval),
        .o_vld   (out_valid),
        .o_dat   (out_data),
        .i_rdy   (out_ready)
    );

endmodule

// File: tb/tb_truth_table_eval.sv
// Self-checking bench for truth_table_eval (N_IN=3, N_OUT=2) with a table-lookup model.
// Directed loads, backpressure, aborted load, async reset, then randomized traffic.
// Parity scenarios are included when TRUTH_TABLE_EVAL_PARITY_EN is defined.
module tb_truth_table_eval;
    import truth_table_eval_pkg::*;

`ifdef TRUTH_TABLE_EVAL_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, cfg_valid, cfg_bit;
    logic       cfg_ready, cfg_done, cfg_err;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_data;
    logic [1:0] out_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_run, m_vld;
    logic [1:0] m_dat;
    logic [15:0] m_tab;

    truth_table_eval #(.N_IN(3), .N_OUT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Output j is table bit j*8 + row.
    function automatic logic [1:0] eval(input logic [15:0] t, input logic [2:0] e);
        int r;
        r = int'(e);
        return {t[8 + r], t[r]};
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic tick(input string tag);
        bit exp_rdy, xfer;
        #1;
        exp_rdy = m_run && (!m_vld || out_ready);
        chk1($sformatf("%s.in_ready", tag), in_ready, exp_rdy);
        xfer = exp_rdy && in_valid && !cfg_start;
        if (cfg_start)      m_vld = 0;
        else if (xfer) begin
            m_vld = 1;
            m_dat = eval(m_tab, in_data);
        end else if (out_ready) m_vld = 0;
        @(posedge clk);
        #1;
        chk1($sformatf("%s.out_valid", tag), out_valid, m_vld);
        if (m_vld) chk2($sformatf("%s.out_data", tag), out_data, m_dat);
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick("cfg_start");
        cfg_start = 1'b0;
        m_run = 0;
        chk1("load.cfg_done_low", cfg_done, 1'b0);
        chk1("load.cfg_ready", cfg_ready, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        tick("cfg_bit");
        cfg_valid = 1'b0;
    endtask

    task automatic load_table(input logic [15:0] tab);
        start_load();
        for (int k = 0; k < 16 + PB; k++) begin
            if (k < 16) send_bit(tab[k]);
            else        send_bit(^tab);
            if (k < 16 + PB - 1) chk1("load.done_early", cfg_done, 1'b0);
        end
        m_tab = tab;
        m_run = 1;
        chk1("load.cfg_done", cfg_done, 1'b1);
        chk1("load.cfg_ready_low", cfg_ready, 1'b0);
        chk1("load.cfg_err", cfg_err, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_bit = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        m_run = 0; m_vld = 0; m_dat = 0; m_tab = 0;

        // Reset values
        #2;
        chk1("rst.cfg_ready", cfg_ready, 1'b0);
        chk1("rst.cfg_done",  cfg_done,  1'b0);
        chk1("rst.cfg_err",   cfg_err,   1'b0);
        chk1("rst.in_ready",  in_ready,  1'b0);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk2("rst.out_data",  out_data,  2'b00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // IDLE ignores inputs
        in_valid = 1'b1; in_data = 3'd6;
        repeat (3) tick("idle");

        // Single-minterm table, in_valid held through the whole load
        load_table({8'h00, WOLFRAM_ONLY_110});
        out_ready = 1'b1;
        for (int e = 0; e < 8; e++) begin
            in_data = 3'(e);
            tick("sweep40");
        end
        in_valid = 1'b0;
        tick("sweep40.drain");

        // Backpressure with a two-output table
        load_table({WOLFRAM_MAJ, WOLFRAM_XOR3});
        in_valid = 1'b1; in_data = 3'd5; out_ready = 1'b1;
        tick("bp.first");
        in_data = 3'd2; out_ready = 1'b0;
        repeat (3) tick("bp.hold");
        out_ready = 1'b1;
        tick("bp.release");
        in_valid = 1'b0;
        tick("bp.drain");

        // Aborted load then full reload of all ones
        start_load();
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        chk1("abort.done_low", cfg_done, 1'b0);
        load_table({WOLFRAM_ALL_ONES, WOLFRAM_ALL_ONES});
        in_valid = 1'b1;
        for (int e = 0; e < 8; e++) begin
            in_data = 3'(e);
            tick("sweepFF");
        end

        // Asynchronous reset with a result pending
        chk1("arst.pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("arst.out_valid", out_valid, 1'b0);
        chk2("arst.out_data",  out_data,  2'b00);
        chk1("arst.cfg_done",  cfg_done,  1'b0);
        chk1("arst.cfg_ready", cfg_ready, 1'b0);
        chk1("arst.in_ready",  in_ready,  1'b0);
        m_run = 0; m_vld = 0; m_tab = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) tick("arst.after");

`ifdef TRUTH_TABLE_EVAL_PARITY_EN
        // Wrong parity bit: 8'h40 has odd weight, so 0 breaks even parity
        start_load();
        for (int k = 0; k < 16; k++) send_bit(k == 6);
        send_bit(1'b0);
        chk1("par.cfg_err",  cfg_err,  1'b1);
        chk1("par.cfg_done", cfg_done, 1'b0);
        tick("par.err_state");
        load_table({8'h00, WOLFRAM_ONLY_110});
        chk1("par.ok_err", cfg_err, 1'b0);
`endif

        // Randomized traffic over several random tables, reloads mid-stream
        for (int t = 0; t < 4; t++) begin
            load_table(16'($urandom));
            for (int c = 0; c < 150; c++) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = 3'($urandom);
                out_ready = (($urandom % 4) != 0);
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
